// File: rtl/wieg_aandrijving_if.sv
// Command/status bundle between the rocking controller and the cradle drive.
// The controller (master) drives amplitude/frequency; the drive (slave) returns position, PWM and status.
interface wieg_aandrijving_if;
  logic [3:0] A;
  logic [3:0] F;
  logic [7:0] pos;
  logic       pwm;
  logic       richting;
  logic       nulDoorgang;

  modport master (
    output A,
    output F,
    input  pos,
    input  pwm,
    input  richting,
    input  nulDoorgang
  );

  modport slave (
    input  A,
    input  F,
    output pos,
    output pwm,
    output richting,
    output nulDoorgang
  );
endinterface

// File: rtl/wieg_aandrijving.sv
// Cradle rocking drive: triangle-wave position setpoint, direction, centre-crossing pulse and PWM.
// Optional macro SOFTSTART_EN: amplitude ramps by one step per latch point instead of jumping.
module wieg_aandrijving #(
  parameter int unsigned CLK_DIV = 1000
) (
  input  logic               clk,
  input  logic               reset,
  wieg_aandrijving_if.slave  bus
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 32'd1);

  logic [15:0] presc_r;
  logic [9:0]  phase_r;
  logic [3:0]  a_act_r;
  logic [3:0]  f_act_r;
  logic [7:0]  pwm_cnt_r;
  logic [7:0]  pos_r;
  logic        pwm_r;
  logic        rich_r;
  logic        nul_r;

  logic        tick_s;
  logic [9:0]  phase_nxt_s;
  logic        toggle_s;
  logic        idle_s;
  logic        latch_s;
  logic [3:0]  a_nxt_s;
  logic [3:0]  f_nxt_s;
  logic [6:0]  off_s;
  logic [7:0]  pos_nxt_s;
  logic        rich_nxt_s;
  logic        pwm_nxt_s;

  function automatic logic [6:0] offset_of(input logic [9:0] ph, input logic [3:0] amp);
    logic [7:0]  w;
    logic [11:0] prod;
    w    = ph[8] ? ~ph[7:0] : ph[7:0];
    prod = {4'b0000, w} * {8'b0000_0000, amp};
    return prod[11:5];
  endfunction

`ifdef SOFTSTART_EN
  function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
    logic [3:0] res;
    if (tgt > cur) begin
      res = cur + 4'd1;
    end else if (tgt < cur) begin
      res = cur - 4'd1;
    end else begin
      res = cur;
    end
    return res;
  endfunction
`endif

  // Tick, phase step, latch decision and next-value computation for all registers.
  always_comb begin
    tick_s      = (presc_r == DIV_LAST);
    phase_nxt_s = phase_r + {6'b00_0000, f_act_r};
    // A wrap 1023 -> 0 also flips bit 9, so it is a crossing like 511 -> 512.
    toggle_s    = tick_s & (phase_nxt_s[9] ^ phase_r[9]);
    idle_s      = (a_act_r == 4'd0) | (f_act_r == 4'd0);
    latch_s     = tick_s & (toggle_s | idle_s);

    a_nxt_s = a_act_r;
    f_nxt_s = f_act_r;
    if (latch_s) begin
      f_nxt_s = bus.F;
`ifdef SOFTSTART_EN
      a_nxt_s = step_toward(a_act_r, bus.A);
`else
      a_nxt_s = bus.A;
`endif
    end else begin
      a_nxt_s = a_act_r;
      f_nxt_s = f_act_r;
    end

    off_s = offset_of(phase_r, a_act_r);
    if (phase_r[9]) begin
      pos_nxt_s = 8'd128 - {1'b0, off_s};
    end else begin
      pos_nxt_s = 8'd128 + {1'b0, off_s};
    end

    if (idle_s) begin
      rich_nxt_s = 1'b0;
    end else begin
      rich_nxt_s = (phase_r[9] == phase_r[8]);
    end

    pwm_nxt_s = (pwm_cnt_r < pos_r);
  end

  // Prescaler, phase accumulator and active command registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r <= 16'd0;
      phase_r <= 10'd0;
      a_act_r <= 4'd0;
      f_act_r <= 4'd0;
    end else begin
      if (tick_s) begin
        presc_r <= 16'd0;
        phase_r <= phase_nxt_s;
      end else begin
        presc_r <= presc_r + 16'd1;
        phase_r <= phase_r;
      end
      a_act_r <= a_nxt_s;
      f_act_r <= f_nxt_s;
    end
  end

  // Registered outputs; pos follows phase one clock later, pwm follows pos.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt_r <= 8'd0;
      pos_r     <= 8'd128;
      pwm_r     <= 1'b0;
      rich_r    <= 1'b0;
      nul_r     <= 1'b0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 8'd1;
      pos_r     <= pos_nxt_s;
      pwm_r     <= pwm_nxt_s;
      rich_r    <= rich_nxt_s;
      nul_r     <= toggle_s;
    end
  end

  assign bus.pos         = pos_r;
  assign bus.pwm         = pwm_r;
  assign bus.richting    = rich_r;
  assign bus.nulDoorgang = nul_r;

endmodule

// File: tb/tb_wieg_aandrijving.sv
// Bench for wieg_aandrijving: two instances (CLK_DIV = 1 and 4) share stimulus and are
// checked every cycle against a triangle-wave model plus hand-computed literal points.
module tb_wieg_aandrijving;

`ifdef SOFTSTART_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic clk;
  logic reset;
  logic [3:0] a_in;
  logic [3:0] f_in;
  int total;
  int bad;
  int edges;

  wieg_aandrijving_if if0();
  wieg_aandrijving_if if1();

  assign if0.A = a_in;
  assign if0.F = f_in;
  assign if1.A = a_in;
  assign if1.F = f_in;

  wieg_aandrijving #(.CLK_DIV(1)) u0 (.clk(clk), .reset(reset), .bus(if0));
  wieg_aandrijving #(.CLK_DIV(4)) u1 (.clk(clk), .reset(reset), .bus(if1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int cnt; int phase; int a; int f; int pwmcnt;
    int pos; int pwm; int rich; int nul;
  } model_t;

  model_t md [2];
  int div_of [2] = '{1, 4};

  function automatic int pos_of(input int ph, input int amp);
    int tri_v;
    int off;
    tri_v = ph % 512;
    if (tri_v >= 256) tri_v = 511 - tri_v;
    off = (tri_v * amp) / 32;
    return (ph < 512) ? 128 + off : 128 - off;
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m.cnt = 0; m.phase = 0; m.a = 0; m.f = 0; m.pwmcnt = 0;
    m.pos = 128; m.pwm = 0; m.rich = 0; m.nul = 0;
    return m;
  endfunction

  function automatic model_t step(input model_t m, input int div, input int a_cmd, input int f_cmd);
    model_t n;
    int nph;
    bit tick;
    bit tog;
    bit latch;
    n     = m;
    tick  = (m.cnt == div - 1);
    nph   = (m.phase + m.f) % 1024;
    tog   = tick && ((nph / 512) != (m.phase / 512));
    latch = tick && (tog || m.a == 0 || m.f == 0);
    n.pwm  = (m.pwmcnt < m.pos) ? 1 : 0;
    n.pos  = pos_of(m.phase, m.a);
    n.rich = (m.a != 0 && m.f != 0 && (m.phase < 256 || m.phase >= 768)) ? 1 : 0;
    n.nul  = tog ? 1 : 0;
    n.cnt  = tick ? 0 : m.cnt + 1;
    n.phase = tick ? nph : m.phase;
    if (latch) begin
      n.f = f_cmd;
      if (!SOFT) n.a = a_cmd;
      else if (a_cmd > m.a) n.a = m.a + 1;
      else if (a_cmd < m.a) n.a = m.a - 1;
    end
    n.pwmcnt = (m.pwmcnt + 1) % 256;
    return n;
  endfunction

  // Model state advance, reset asynchronously like the design.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      md[0] <= model_reset();
      md[1] <= model_reset();
      edges <= 0;
    end else begin
      md[0] <= step(md[0], div_of[0], int'(a_in), int'(f_in));
      md[1] <= step(md[1], div_of[1], int'(a_in), int'(f_in));
      edges <= edges + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("u0.pos", int'(if0.pos), md[0].pos);
    check("u0.pwm", int'(if0.pwm), md[0].pwm);
    check("u0.richting", int'(if0.richting), md[0].rich);
    check("u0.nulDoorgang", int'(if0.nulDoorgang), md[0].nul);
    check("u1.pos", int'(if1.pos), md[1].pos);
    check("u1.pwm", int'(if1.pwm), md[1].pwm);
    check("u1.richting", int'(if1.richting), md[1].rich);
    check("u1.nulDoorgang", int'(if1.nulDoorgang), md[1].nul);
  end

  task automatic go_to(input int n);
    while (edges < n) @(negedge clk);
  endtask

  task automatic restart(input logic [3:0] a, input logic [3:0] f);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    a_in = a;
    f_in = f;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int nul_seen;
    int rich_seen;
    int hi0;
    int hi1;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    a_in  = 4'd15;
    f_in  = 4'd15;

    // Held in reset with a full command applied.
    repeat (20) begin
      @(negedge clk);
      check("rst.pos", int'(if0.pos), 128);
      check("rst.pwm", int'(if0.pwm), 0);
      check("rst.nul", int'(if1.nulDoorgang), 0);
    end

    // Full amplitude, slowest step, CLK_DIV = 1 instance pinned by literals.
    restart(4'd15, 4'd1);
    go_to(101);
    check("lit.rich_rising", int'(if0.richting), 1);
    go_to(257);
    check("lit.pos_peak", int'(if0.pos), SOFT ? 135 : 247);
    go_to(400);
    check("lit.rich_falling", int'(if0.richting), 0);
    go_to(513);
    check("lit.nul_512", int'(if0.nulDoorgang), 1);
    go_to(514);
    check("lit.nul_512_off", int'(if0.nulDoorgang), 0);
    go_to(770);
    check("lit.pos_trough", int'(if0.pos), SOFT ? 113 : 9);
    go_to(1025);
    check("lit.nul_wrap", int'(if0.nulDoorgang), 1);

    // Asynchronous reset in mid-swing, observed before any clock edge.
    go_to(1200);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async.pos", int'(if0.pos), 128);
    check("async.pwm", int'(if0.pwm), 0);
    check("async.rich", int'(if0.richting), 0);

    // Frequency change mid half-cycle takes effect only at the next crossing.
    restart(4'd8, 4'd4);
    go_to(200);
    f_in = 4'd8;
    go_to(509);
    check("lit.step4_pos", int'(if1.pos), SOFT ? 128 : 129);
    go_to(516);
    check("lit.cross_nul", int'(if1.nulDoorgang), 1);
    go_to(517);
    check("lit.cross_nul_off", int'(if1.nulDoorgang), 0);
    go_to(521);
    check("lit.step8_pos_a", int'(if1.pos), SOFT ? 128 : 126);
    go_to(525);
    check("lit.step8_pos_b", int'(if1.pos), SOFT ? 127 : 124);

    // Frequency zero latched at a crossing freezes the swing.
    restart(4'd15, 4'd5);
    go_to(60);
    f_in = 4'd0;
    go_to(500);
    check("lit.freeze_pos0", int'(if0.pos), 127);
    check("lit.freeze_pos1", int'(if1.pos), 127);
    nul_seen  = 0;
    rich_seen = 0;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      if (if0.nulDoorgang || if1.nulDoorgang) nul_seen++;
      if (if0.richting || if1.richting) rich_seen++;
    end
    check("lit.freeze_nul_count", nul_seen, 0);
    check("lit.freeze_rich_count", rich_seen, 0);
    check("lit.freeze_pos_end", int'(if1.pos), 127);

    // Zero amplitude: centre position, 50% PWM duty.
    restart(4'd0, 4'd3);
    go_to(300);
    hi0 = 0;
    hi1 = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (if0.pwm) hi0++;
      if (if1.pwm) hi1++;
    end
    check("lit.duty0", hi0, 128);
    check("lit.duty1", hi1, 128);
    check("lit.centre_pos", int'(if0.pos), 128);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
